// File: rtl/nexi_uart_pkg.sv
// Shared UART definitions: receive FSM states and default frame geometry.
package nexi_uart_pkg;

   localparam int unsigned UART_OVERSAMPLE  = 16;
   localparam int unsigned UART_DATA_BITS   = 8;
   // 8N1: start + data + stop
   localparam int unsigned UART_FRAME_BITS  = 1 + UART_DATA_BITS + 1;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_HIGH
   } uart_rx_state_t;

endpackage

// File: rtl/nexi_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input, with selectable reset value.
module nexi_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/nexi_uart_rx.sv
// 8N1 UART receiver on a 16x oversampled clock: mid-bit start validation, centre sampling,
// stop-bit check, valid/ack delivery with framing and overrun pulses.
module nexi_uart_rx
   import nexi_uart_pkg::*;
#(
   parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
   parameter int unsigned DATA_BITS  = UART_DATA_BITS
) (
   input  logic                 clk_16x_bps,
   input  logic                 rst,
   input  logic                 rx_pin,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ack,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);

   localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

   logic                 rxs;
   uart_rx_state_t       state, state_nx;
   logic [CNT_W-1:0]     cnt;
   logic [BIT_W-1:0]     bitn;
   logic [DATA_BITS-1:0] shreg;

   logic cnt_clr_c, cnt_inc_c, bit_clr_c, shift_c, stop_good_c, stop_bad_c;

   nexi_sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk (clk_16x_bps),
      .rst (rst),
      .d   (rx_pin),
      .q   (rxs)
   );

   always_ff @(posedge clk_16x_bps) begin
      if (rst) state <= RX_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         RX_IDLE:      if (!rxs) state_nx = RX_START;
         RX_START:     if (cnt == HALF_M1) state_nx = rxs ? RX_IDLE : RX_DATA;
         RX_DATA:      if (cnt == FULL_M1 && bitn == LAST_BIT) state_nx = RX_STOP;
         RX_STOP:      if (cnt == FULL_M1) state_nx = rxs ? RX_IDLE : RX_WAIT_HIGH;
         RX_WAIT_HIGH: if (rxs) state_nx = RX_IDLE;
         default:      state_nx = RX_IDLE;
      endcase
   end

   // Datapath strobes; every sample point also clears the tick counter.
   always_comb begin
      cnt_clr_c   = 1'b0;
      cnt_inc_c   = 1'b0;
      bit_clr_c   = 1'b0;
      shift_c     = 1'b0;
      stop_good_c = 1'b0;
      stop_bad_c  = 1'b0;
      case (state)
         RX_IDLE: begin
            if (!rxs) begin
               cnt_clr_c = 1'b1;
               bit_clr_c = 1'b1;
            end
         end
         RX_START: begin
            if (cnt == HALF_M1) cnt_clr_c = 1'b1;
            else                cnt_inc_c = 1'b1;
         end
         RX_DATA: begin
            if (cnt == FULL_M1) begin
               cnt_clr_c = 1'b1;
               shift_c   = 1'b1;
            end else begin
               cnt_inc_c = 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt == FULL_M1) begin
               cnt_clr_c   = 1'b1;
               stop_good_c = rxs;
               stop_bad_c  = !rxs;
            end else begin
               cnt_inc_c = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_16x_bps) begin
      if (rst) begin
         cnt       <= '0;
         bitn      <= '0;
         shreg     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= stop_bad_c;
         overrun   <= stop_good_c && rx_valid && !rx_ack;

         if (cnt_clr_c)      cnt <= '0;
         else if (cnt_inc_c) cnt <= cnt + CNT_W'(1);

         if (bit_clr_c)      bitn <= '0;
         else if (shift_c)   bitn <= bitn + BIT_W'(1);

         // LSB arrives first, so each new bit enters at the top and walks down.
         if (shift_c) shreg <= {rxs, shreg[DATA_BITS-1:1]};

         // A same-cycle ack frees the holding register for the new byte.
         if (stop_good_c && (!rx_valid || rx_ack)) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
         end else if (rx_ack) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_nexi_uart_rx.sv
// Directed and randomized frames for nexi_uart_rx, checked against a byte-level delivery model.
module tb_nexi_uart_rx;

   localparam int OS  = 16;
   localparam int DB  = 8;
   localparam int LAT = 2 + OS / 2 + OS * (DB + 1) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          rx_pin;
   logic          rx_ack;
   logic [DB-1:0] rx_data;
   logic          rx_valid;
   logic          frame_err;
   logic          overrun;

   always #5 clk = ~clk;

   nexi_uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
      .clk_16x_bps (clk),
      .rst         (rst),
      .rx_pin      (rx_pin),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ack      (rx_ack),
      .frame_err   (frame_err),
      .overrun     (overrun)
   );

   int checks   = 0;
   int failures = 0;

   int   cyc       = 0;
   int   fe_cnt    = 0;
   int   ov_cnt    = 0;
   int   rise_cyc  = -1;
   logic prev_valid = 1'b0;
   int   e_cyc     = 0;

   // Model: what the consumer should see, derived from frame outcomes only.
   logic          exp_valid = 1'b0;
   logic [DB-1:0] exp_data  = '0;
   int            exp_fe    = 0;
   int            exp_ov    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse counters count high cycles, so a wide pulse shows up as an extra count.
   always @(negedge clk) begin
      if (frame_err === 1'b1) fe_cnt++;
      if (overrun === 1'b1)   ov_cnt++;
      if (rx_valid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
      prev_valid = rx_valid;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_data"},  32'(rx_data),  32'(exp_data));
      chk({tag, "_valid"}, 32'(rx_valid), 32'(exp_valid));
      chk({tag, "_fe"},    32'(fe_cnt),   32'(exp_fe));
      chk({tag, "_ov"},    32'(ov_cnt),   32'(exp_ov));
   endtask

   // Bit-accurate 8N1 waveform; the line is left at the stop-bit level.
   task automatic send_frame(input logic [DB-1:0] b, input logic stop);
      @(negedge clk);
      rx_pin = 1'b0;
      e_cyc  = cyc + 1;
      repeat (OS) @(negedge clk);
      for (int i = 0; i < DB; i++) begin
         rx_pin = b[i];
         repeat (OS) @(negedge clk);
      end
      rx_pin = stop;
      repeat (OS) @(negedge clk);
   endtask

   task automatic model_frame(input logic [DB-1:0] b, input logic stop, input logic ack_at_stop);
      if (!stop)                          exp_fe++;
      else if (exp_valid && !ack_at_stop) exp_ov++;
      else begin
         exp_data  = b;
         exp_valid = 1'b1;
      end
   endtask

   task automatic do_ack();
      @(negedge clk);
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack    = 1'b0;
      exp_valid = 1'b0;
   endtask

   initial begin
      rst    = 1'b1;
      rx_pin = 1'b1;
      rx_ack = 1'b0;
      repeat (3) @(negedge clk);
      check_state("reset");
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // First byte: value, latency from first low capture, no flags.
      send_frame(8'hA5, 1'b1);
      model_frame(8'hA5, 1'b1, 1'b0);
      chk("latency_a5", 32'(rise_cyc - e_cyc + 1), 32'(LAT));
      check_state("frame_a5");

      // Short low glitch must be rejected at start validation.
      do_ack();
      @(negedge clk);
      rx_pin = 1'b0;
      repeat (4) @(negedge clk);
      rx_pin = 1'b1;
      repeat (200) @(negedge clk);
      check_state("glitch");

      // Low stop bit, then line stuck low: one error pulse, no phantom frame.
      send_frame(8'h3C, 1'b0);
      model_frame(8'h3C, 1'b0, 1'b0);
      repeat (40) @(negedge clk);
      check_state("break_low");
      rx_pin = 1'b1;
      repeat (200) @(negedge clk);
      check_state("break_released");

      // Overrun: second byte dropped while first is unconsumed.
      send_frame(8'h11, 1'b1);
      model_frame(8'h11, 1'b1, 1'b0);
      check_state("ovr_first");
      send_frame(8'h22, 1'b1);
      model_frame(8'h22, 1'b1, 1'b0);
      check_state("ovr_second");
      do_ack();
      check_state("ovr_acked");
      send_frame(8'h33, 1'b1);
      model_frame(8'h33, 1'b1, 1'b0);
      check_state("after_ovr");

      // Ack coinciding with the stop-sample edge lets the new byte in.
      do_ack();
      send_frame(8'h44, 1'b1);
      model_frame(8'h44, 1'b1, 1'b0);
      check_state("pend_44");
      fork
         send_frame(8'h55, 1'b1);
         begin
            @(negedge clk);
            repeat (LAT - 1) @(negedge clk);
            rx_ack = 1'b1;
            @(negedge clk);
            rx_ack = 1'b0;
         end
      join
      model_frame(8'h55, 1'b1, 1'b1);
      check_state("ack_at_stop");

      // Reset in the middle of data bit 4 of 0xFF.
      fork
         send_frame(8'hFF, 1'b1);
         begin
            @(negedge clk);
            repeat (OS * 5 + OS / 2) @(negedge clk);
            rst = 1'b1;
            repeat (4) @(negedge clk);
            chk("in_reset_valid", 32'(rx_valid),  32'd0);
            chk("in_reset_data",  32'(rx_data),   32'd0);
            chk("in_reset_fe",    32'(frame_err), 32'd0);
            chk("in_reset_ov",    32'(overrun),   32'd0);
            rst = 1'b0;
         end
      join
      exp_valid = 1'b0;
      exp_data  = '0;
      repeat (50) @(negedge clk);
      check_state("post_reset");
      send_frame(8'h81, 1'b1);
      model_frame(8'h81, 1'b1, 1'b0);
      check_state("frame_81");

      // Random bytes, random stop errors, random consumption and gaps.
      for (int i = 0; i < 24; i++) begin
         logic [DB-1:0] b;
         logic          stop;
         b    = DB'($urandom);
         stop = ($urandom_range(0, 5) != 0);
         if ($urandom_range(0, 1) == 1) do_ack();
         send_frame(b, stop);
         rx_pin = 1'b1;
         model_frame(b, stop, 1'b0);
         repeat ($urandom_range(1, 20)) @(negedge clk);
         check_state($sformatf("rand%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nexi_uart_rx.md
# nexi_uart_rx

UART receive stage, the downstream peer of the UART transmitter: it deserialises an 8N1 frame from `rx_pin` and delivers the byte with a valid/ack handshake. It runs on a 16× oversampled bit clock. It synchronises the asynchronous line, validates the start bit at mid-bit, and samples data LSB first at bit centres. It checks the stop bit and reports framing and overrun errors. It sits between the board RX pin and the CPU-side UART register block.

## Interface
- `OVERSAMPLE`, 16, clock ticks per bit period; even, ≥ 4.
- `DATA_BITS`, 8, data bits per frame; fixed 1 start bit, 1 stop bit, no parity.
- `clk_16x_bps`  in  1  single clock, OVERSAMPLE × baud.
- `rst`  in  1  synchronous, active-high reset.
- `rx_pin`  in  1  asynchronous serial line; idles high.
- `rx_data`  out  DATA_BITS  last good byte; LSB first on the wire.
- `rx_valid`  out  1  `rx_data` holds an unconsumed byte.
- `rx_ack`  in  1  consumer takes the byte; sampled every cycle.
- `frame_err`  out  1  one-cycle pulse; stop bit sampled low.
- `overrun`  out  1  one-cycle pulse; frame completed while `rx_valid` was high and `rx_ack` was low.

## Operation
- Two-flop synchroniser on `rx_pin`; both flops reset to 1. Logic below uses only the synchronised value `rxs`.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: when `rxs`==0, clear `cnt` and `bitn`, go to START.
- START: increment `cnt` each cycle. At `cnt`==OVERSAMPLE/2−1:
  - `rxs`==0: clear `cnt`, go to DATA.
  - `rxs`==1: glitch; return to IDLE with no output and no flag.
- DATA: sample `rxs` at `cnt`==OVERSAMPLE−1, then clear `cnt`.
  - Shift right into the MSB of `shreg`.
  - Increment `bitn`; after DATA_BITS samples, go to STOP.
- STOP: sample at `cnt`==OVERSAMPLE−1.
  - `rxs`==1: load `shreg` into `rx_data`, set `rx_valid`, go to IDLE.
  - `rxs`==0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH (break / stuck-low line): stay until `rxs`==1, then go to IDLE.
- Handshake:
  - `rx_valid` is cleared on any cycle where `rx_ack`=1, unless a new byte loads on that same cycle.
  - `rx_ack` while `rx_valid`=0 is ignored.
- Overrun, on a good stop bit with `rx_valid`=1 and `rx_ack`=0:
  - Pulse `overrun`.
  - New byte is dropped; `rx_data` and `rx_valid` keep the old byte.
- Simultaneous good stop bit and `rx_ack`=1: new byte loads, `rx_valid` stays 1, no overrun.
- A good frame that ends in STOP→IDLE may be followed immediately by the next start bit; no idle cycles are required.
- Widths:
  - `cnt` is $clog2(OVERSAMPLE) bits and never wraps unintentionally; it is always cleared at a sample point.
  - `bitn` is $clog2(DATA_BITS+1) bits.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, state=IDLE, sync flops=1.
- Reset mid-frame aborts the frame immediately. No partial byte is delivered and no flag is raised.
- Let edge E be the first edge at which `rx_pin` is captured low.
  - `rxs` goes low 2 edges after E.
  - Start is validated OVERSAMPLE/2 cycles later.
  - Data bit k (k=0..DATA_BITS−1) is sampled OVERSAMPLE·(k+1) cycles after start validation.
  - Stop bit is sampled OVERSAMPLE·(DATA_BITS+1) cycles after start validation.
- `rx_valid`, `frame_err` and `overrun` are registered. They become visible the cycle after the stop-sample edge.
- Total from E to `rx_valid` high, in clock cycles: 2 + OVERSAMPLE/2 + OVERSAMPLE·(DATA_BITS+1) + 1 = 155 for defaults.
- `frame_err` and `overrun` are exactly one cycle wide.

## Structure
- Shared package `nexi_uart_pkg` holds:
  - the state enum `uart_rx_state_t`;
  - default constants `UART_OVERSAMPLE`=16 and `UART_DATA_BITS`=8, also used by the TX side;
  - the 8N1 frame length constant.
- One sub-module, `nexi_sync2`: a two-flop synchroniser with a reset-value parameter, reusable by the TX command input.
- Everything else (FSM, counters, shift register, output regs) lives in one always block plus next-state logic.

## Test plan
- Reset then frame 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop) at 16 ticks/bit, hold `rx_ack` low → `rx_valid` rises 155 cycles after the first low capture; `rx_data`=0xA5; no flags.
- 4-cycle low glitch on an idle line → no state change beyond START, `rx_valid` stays 0, no `frame_err`.
- Frame 0x3C with stop bit driven low, line then held low for 40 cycles → one-cycle `frame_err` pulse; `rx_valid` stays 0; no new start detected until line returns high.
- Frame 0x11 received, then 0x22 back-to-back without `rx_ack` → `overrun` pulses once; `rx_data` stays 0x11. Ack, then send 0x33 → `rx_data`=0x33.
- `rx_ack` asserted on the exact cycle 0x55's stop sample completes, with 0x44 pending → `rx_data`=0x55, `rx_valid`=1, no `overrun`.
- `rst` asserted midway through data bit 4 of 0xFF, released, then 0x81 sent → only 0x81 delivered; all outputs 0 during and after reset until then.
